// File: rtl/regfile_xfer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_xfer_ctrl_pkg
//   Shared definitions for the register-file bulk-transfer controller:
//   command op encoding, FSM state encoding and the default register-file
//   geometry, which the register file itself also uses.
//   Optional macro: REGXFER_CHECKSUM_EN adds the two checksum-beat states.
// ---------------------------------------------------------------------------
package regfile_xfer_ctrl_pkg;

    localparam int DEF_N_REGS    = 8;
    localparam int DEF_REG_WIDTH = 8;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_DUMP = 1'b1;

`ifdef REGXFER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DUMP,
        ST_DONE,
        ST_LOAD_CSUM,
        ST_DUMP_CSUM
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DUMP,
        ST_DONE
    } state_e;
`endif

endpackage

// File: rtl/regxfer_ptr.sv
// ---------------------------------------------------------------------------
// regxfer_ptr
//   Register index counter with wrap at N_REGS-1 plus a remaining-beats
//   down-counter.
//   Ports:
//     clk, reset        clock, synchronous active-high reset (both go to 0)
//     load              capture load_ptr / load_count
//     step              advance index (with wrap) and decrement remaining
//     load_ptr          first register index
//     load_count        number of beats in the run
//     ptr               current register index
//     last              remaining == 1 (the current beat is the final one)
// ---------------------------------------------------------------------------
module regxfer_ptr #(
    parameter int N_REGS     = 8,
    parameter int ADDR_WIDTH = $clog2(N_REGS),
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] load_ptr,
    input  logic [CNT_WIDTH-1:0]  load_count,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_REGS - 1);

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;

    always_comb begin
        ptr_d = ptr_q;
        rem_d = rem_q;
        if (load) begin
            ptr_d = load_ptr;
            rem_d = load_count;
        end else if (step) begin
            // ">=" rather than "==" so an out-of-range start index folds
            // back to 0 on its first step.
            ptr_d = (ptr_q >= LAST_IDX) ? '0 : ptr_q + 1'b1;
            rem_d = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
        end
    end

    assign ptr  = ptr_q;
    assign last = (rem_q == CNT_WIDTH'(1));

endmodule

// File: rtl/regfile_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_xfer_ctrl
//   Bulk-transfer initiator owning the register file write/read ports.
//   LOAD streams in_data words into a run of registers; DUMP streams a run
//   of registers out. busy stalls the core; done pulses once at the end.
//   Ports:
//     cmd_*            command handshake (op, start index, count; count 0 ok)
//     in_*             inbound valid/ready word stream (LOAD)
//     out_*            outbound valid/ready word stream (DUMP)
//     wreg_index/wdata/write_enable   register file write port
//     rreg_index/rdata                register file read port (comb read)
//     busy, done, err  status
//   Optional macro: REGXFER_CHECKSUM_EN -- appends a mod-2^REG_WIDTH sum
//   beat to every transfer; a mismatching LOAD sum sets err (sticky until
//   the next command). Without it err is tied low.
// ---------------------------------------------------------------------------
module regfile_xfer_ctrl
    import regfile_xfer_ctrl_pkg::*;
#(
    parameter int N_REGS     = DEF_N_REGS,
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int ADDR_WIDTH = $clog2(N_REGS),
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_start,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_WIDTH-1:0]  out_data,
    output logic [ADDR_WIDTH-1:0] wreg_index,
    output logic [REG_WIDTH-1:0]  wdata,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] rreg_index,
    input  logic [REG_WIDTH-1:0]  rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // State entered after the final data beat of each direction.
`ifdef REGXFER_CHECKSUM_EN
    localparam state_e LOAD_END = ST_LOAD_CSUM;
    localparam state_e DUMP_END = ST_DUMP_CSUM;
`else
    localparam state_e LOAD_END = ST_DONE;
    localparam state_e DUMP_END = ST_DONE;
`endif

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  last;
    logic                  in_load, in_dump;
    logic                  cmd_accept, load_beat, dump_beat;

    assign in_load = (state_q == ST_LOAD);
    assign in_dump = (state_q == ST_DUMP);

    // Gating with reset makes an abort take effect in the reset cycle
    // itself: no write, no beat, no pointer step.
    assign cmd_accept = (state_q == ST_IDLE) && cmd_valid && !reset;
    assign load_beat  = in_load && in_valid && !reset;
    assign dump_beat  = in_dump && out_ready && !reset;

    regxfer_ptr #(
        .N_REGS     (N_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_ptr (
        .clk        (clk),
        .reset      (reset),
        .load       (cmd_accept),
        .step       (load_beat || dump_beat),
        .load_ptr   (cmd_start),
        .load_count (cmd_count),
        .ptr        (ptr),
        .last       (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (cmd_count == '0) begin
                        // Zero-length run skips straight to the tail
                        // (checksum beat if built in, else DONE).
                        state_d = (cmd_op == OP_DUMP) ? DUMP_END : LOAD_END;
                    end else begin
                        state_d = (cmd_op == OP_DUMP) ? ST_DUMP : ST_LOAD;
                    end
                end
            end
            ST_LOAD: if (load_beat && last) state_d = LOAD_END;
            ST_DUMP: if (dump_beat && last) state_d = DUMP_END;
`ifdef REGXFER_CHECKSUM_EN
            ST_LOAD_CSUM: if (in_valid) state_d = ST_DONE;
            ST_DUMP_CSUM: if (out_ready) state_d = ST_DONE;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign write_enable = load_beat;
    assign wreg_index   = ptr;
    assign wdata        = in_load ? in_data : '0;
    assign rreg_index   = ptr;

`ifdef REGXFER_CHECKSUM_EN
    logic [REG_WIDTH-1:0] sum_q, sum_d;
    logic                 err_q, err_d;
    logic                 in_lcsum, in_dcsum;

    assign in_lcsum = (state_q == ST_LOAD_CSUM);
    assign in_dcsum = (state_q == ST_DUMP_CSUM);

    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (cmd_accept) begin
            sum_d = '0;
            err_d = 1'b0;
        end else if (load_beat) begin
            sum_d = sum_q + in_data;
        end else if (dump_beat) begin
            sum_d = sum_q + rdata;
        end else if (in_lcsum && in_valid && (in_data != sum_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign in_ready  = (in_load || in_lcsum) && !reset;
    assign out_valid = (in_dump || in_dcsum) && !reset;
    assign out_data  = in_dump ? rdata : (in_dcsum ? sum_q : '0);
    assign err       = err_q;
`else
    assign in_ready  = in_load && !reset;
    assign out_valid = in_dump && !reset;
    assign out_data  = in_dump ? rdata : '0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_xfer_ctrl
//   Bench for regfile_xfer_ctrl with a behavioural register file attached.
//   Table of commands plus hand-written reset-abort, held-command and
//   (with REGXFER_CHECKSUM_EN) checksum sequences; expected writes and out
//   words go through scoreboard queues.
// ---------------------------------------------------------------------------
module tb_regfile_xfer_ctrl;
    import regfile_xfer_ctrl_pkg::*;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int AW = 3;
    localparam int CW = 4;
`ifdef REGXFER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [AW-1:0] cmd_start;
    logic [CW-1:0] cmd_count;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_data;
    logic [AW-1:0] wreg_index, rreg_index;
    logic [W-1:0]  wdata, rdata;
    logic          write_enable, busy, done, err;

    always #5 clk = ~clk;

    regfile_xfer_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_start    (cmd_start),
        .cmd_count    (cmd_count),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .wreg_index   (wreg_index),
        .wdata        (wdata),
        .write_enable (write_enable),
        .rreg_index   (rreg_index),
        .rdata        (rdata),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Behavioural register file (environment, not a reference model).
    logic [W-1:0] regs [N];
    logic         fill;
    assign rdata = regs[rreg_index];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < N; i++) regs[i] <= W'(i * 17 + 3);
        end else if (write_enable) begin
            regs[wreg_index] <= wdata;
        end
    end

    // Reference state and scoreboards
    typedef struct packed {
        logic [AW-1:0] idx;
        logic [W-1:0]  data;
    } wr_t;

    logic [W-1:0] exp_regs [N];
    wr_t          wr_q[$];
    logic [W-1:0] out_q[$];
    logic [W-1:0] fixed_q[$];
    logic         last_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, nothing expected (cycle %0d)", name, act, cyc);
    endtask

    function automatic logic [W-1:0] next_data();
        if (fixed_q.size() != 0) return fixed_q.pop_front();
        return W'($urandom_range(0, 255));
    endfunction

    // Monitor: scoreboard pops, stall stability, done pulse width.
    initial begin
        wr_t          we;
        logic [W-1:0] eo;
        logic         prev_done = 1'b0;
        logic         hold_v = 1'b0;
        logic [W-1:0] hold_d = '0;
        logic [AW-1:0] hold_i = '0;
        forever begin
            @(negedge clk);
            if (write_enable) begin
                if (wr_q.size() == 0) begin
                    fail("stray_write", {24'd0, wreg_index, 5'd0} | 32'(wdata));
                end else begin
                    we = wr_q.pop_front();
                    check("wr_index", 32'(wreg_index), 32'(we.idx));
                    check("wr_data", 32'(wdata), 32'(we.data));
                end
            end
            if (out_valid) begin
                if (hold_v) begin
                    check("hold_data", 32'(out_data), 32'(hold_d));
                    check("hold_index", 32'(rreg_index), 32'(hold_i));
                end
                if (out_ready) begin
                    if (out_q.size() == 0) begin
                        fail("stray_out", 32'(out_data));
                    end else begin
                        eo = out_q.pop_front();
                        check("out_data", 32'(out_data), 32'(eo));
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    hold_d = out_data;
                    hold_i = rreg_index;
                end
            end else begin
                hold_v = 1'b0;
            end
            if (done) begin
                check("done_single", 32'(prev_done), 32'd0);
                done_cnt++;
                done_cyc = cyc;
            end
            prev_done = done;
        end
    end

    // One command: drive, stream, wait for done, check tail state.
    task automatic run_cmd(input logic op, input int start, input int count,
                           input bit toggle, input bit bad, input int exp_lat);
        int           acc_cyc, beat, total, guard, d0;
        bit           ph;
        logic [W-1:0] sum, d;
        wr_t          e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_start = AW'(start);
        cmd_count = CW'(count);
        @(negedge clk);
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        check("err_sticky", 32'(err), 32'(last_err));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc_cyc   = cyc;
        d0        = done_cnt;
        sum       = '0;
        if (op == OP_DUMP) begin
            for (int k = 0; k < count; k++) begin
                d = exp_regs[(start + k) % N];
                out_q.push_back(d);
                sum += d;
            end
            if (CS != 0) out_q.push_back(sum);
        end
        beat  = 0;
        total = count + ((op == OP_LOAD) ? CS : 0);
        guard = 0;
        while (done_cnt == d0 && guard < 100) begin
            ph = !toggle || (guard % 2 == 1);
            if (op == OP_LOAD) begin
                if (beat < total && ph) begin
                    in_valid = 1'b1;
                    if (beat < count) begin
                        d = next_data();
                        in_data = d;
                        e.idx  = AW'((start + beat) % N);
                        e.data = d;
                        wr_q.push_back(e);
                        exp_regs[(start + beat) % N] = d;
                        sum += d;
                    end else begin
                        in_data = bad ? (sum ^ W'(1)) : sum;
                    end
                    beat++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                out_ready = ph;
            end
            @(negedge clk);
            if (guard == 0) check("busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (guard >= 100) fail("done_timeout", 32'(guard));
        else check("latency", 32'(done_cyc - acc_cyc), 32'(exp_lat));
        check("done_count", 32'(done_cnt - d0), 32'd1);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        last_err = (CS != 0) && bad && (op == OP_LOAD);
        check("err", 32'(err), 32'(last_err));
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("out_q_drained", 32'(out_q.size()), 32'd0);
        @(posedge clk); #1;
        $display("[TB] cmd op=%0d start=%0d count=%0d toggle=%0d latency=%0d",
                 op, start, count, toggle, done_cyc - acc_cyc);
    endtask

    typedef struct {
        logic op;
        int   start;
        int   count;
        bit   toggle;
        bit   bad;
        int   exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, accepts, first_acc, second_acc, dones_at_second, guard;
        logic [W-1:0] d, sum;
        wr_t e;

        vecs[0] = '{OP_LOAD, 2, 3, 1'b0, 1'b0, 3 + CS};
        vecs[1] = '{OP_DUMP, 6, 4, 1'b1, 1'b0, 2 * (4 + CS)};
        vecs[2] = '{OP_LOAD, 0, 0, 1'b0, 1'b0, CS};
        vecs[3] = '{OP_DUMP, 3, 0, 1'b0, 1'b0, CS};
        vecs[4] = '{OP_LOAD, 5, 8, 1'b1, 1'b0, 2 * (8 + CS)};
        vecs[5] = '{OP_DUMP, 7, 8, 1'b0, 1'b0, 8 + CS};
        vecs[6] = '{OP_LOAD, 7, 2, 1'b0, 1'b1, 2 + CS};
        vecs[7] = '{OP_DUMP, 0, 1, 1'b0, 1'b0, 1 + CS};

        for (int i = 0; i < N; i++) exp_regs[i] = W'(i * 17 + 3);
        last_err  = 1'b0;
        reset     = 1'b1;
        fill      = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_start = '0;
        cmd_count = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        @(posedge clk); #1;
        fill = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wreg_index", 32'(wreg_index), 32'd0);
        check("rst_rreg_index", 32'(rreg_index), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table-driven commands
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                fixed_q.push_back(8'hA1);
                fixed_q.push_back(8'hB2);
                fixed_q.push_back(8'hC3);
            end
            run_cmd(vecs[i].op, vecs[i].start, vecs[i].count,
                    vecs[i].toggle, vecs[i].bad, vecs[i].exp_lat);
        end
        for (int i = 0; i < N; i++) check("regfile_after_table", 32'(regs[i]), 32'(exp_regs[i]));

        // Reset after 2 of 5 LOAD beats
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_start = AW'(1);
        cmd_count = CW'(5);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        d0 = done_cnt;
        for (int b = 0; b < 2; b++) begin
            d = next_data();
            in_valid = 1'b1;
            in_data  = d;
            e.idx  = AW'(1 + b);
            e.data = d;
            wr_q.push_back(e);
            exp_regs[1 + b] = d;
            @(posedge clk); #1;
        end
        reset   = 1'b1;
        in_data = 8'h5A;
        @(negedge clk);
        check("abort_write_enable", 32'(write_enable), 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        last_err = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_wr_q", 32'(wr_q.size()), 32'd0);
        for (int i = 0; i < N; i++) check("regfile_after_abort", 32'(regs[i]), 32'(exp_regs[i]));
        $display("[TB] reset abort after 2 of 5 LOAD beats");

        // cmd_valid held high across a DUMP: second command waits for done
        d0 = done_cnt;
        sum = '0;
        for (int k = 0; k < 3; k++) begin
            out_q.push_back(exp_regs[4 + k]);
            sum += exp_regs[4 + k];
        end
        if (CS != 0) out_q.push_back(sum);
        sum = '0;
        for (int k = 0; k < 2; k++) begin
            out_q.push_back(exp_regs[k]);
            sum += exp_regs[k];
        end
        if (CS != 0) out_q.push_back(sum);
        accepts = 0; first_acc = 0; second_acc = 0; dones_at_second = 0;
        cmd_valid = 1'b1;
        cmd_op    = OP_DUMP;
        cmd_start = AW'(4);
        cmd_count = CW'(3);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && accepts < 2; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                accepts++;
                if (accepts == 1) first_acc = cyc;
                else begin
                    second_acc = cyc;
                    dones_at_second = done_cnt - d0;
                end
            end
            @(posedge clk); #1;
            if (accepts == 1) begin
                cmd_start = AW'(0);
                cmd_count = CW'(2);
            end
            if (accepts == 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        check("held_cmd_accepts", 32'(accepts), 32'd2);
        check("held_cmd_gap", 32'(second_acc - first_acc), 32'(5 + CS));
        check("held_cmd_dones_between", 32'(dones_at_second), 32'd1);
        guard = 0;
        while (done_cnt - d0 < 2 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        check("held_cmd_done_total", 32'(done_cnt - d0), 32'd2);
        check("held_cmd_out_q", 32'(out_q.size()), 32'd0);
        $display("[TB] held cmd_valid: accepts at cycles %0d and %0d", first_acc, second_acc);

`ifdef REGXFER_CHECKSUM_EN
        // Checksum beats: 0x10+0x20+0xF0 = 0x20 mod 256
        fixed_q.push_back(8'h10);
        fixed_q.push_back(8'h20);
        fixed_q.push_back(8'hF0);
        run_cmd(OP_LOAD, 0, 3, 1'b0, 1'b0, 4);
        run_cmd(OP_DUMP, 0, 3, 1'b0, 1'b0, 4);
        fixed_q.push_back(8'h10);
        fixed_q.push_back(8'h20);
        fixed_q.push_back(8'hF0);
        run_cmd(OP_LOAD, 0, 3, 1'b0, 1'b1, 4);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("err_held_idle", 32'(err), 32'd1);
        @(posedge clk); #1;
        run_cmd(OP_DUMP, 1, 2, 1'b1, 1'b0, 6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
